// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: run-time programmable serial bit-pattern detector with saturating match counter.
module seq_pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int CNT_WIDTH = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b0001_0110,
    parameter int DEF_LEN = 5,
    parameter bit DEF_OVERLAP = 1'b1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_load,
    input  logic [MAX_LEN-1:0]   cfg_pattern,
    input  logic [LW-1:0]        cfg_len,
    input  logic                 cfg_overlap,
    input  logic                 in_valid,
    input  logic                 stream,
    input  logic                 cnt_clear,
    output logic                 detected,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 count_sat
);
    logic [MAX_LEN-1:0]   pattern, history, hist_n, mask;
    logic [LW-1:0]        len, fill, fill_n;
    logic                 overlap, accept, match;
    logic [CNT_WIDTH-1:0] cnt_inc;

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) mask[i] = LW'(i) < len;
    end

    // Match is judged on the history/fill that include the bit being accepted now.
    assign accept  = in_valid && !cfg_load;
    assign hist_n  = {history[MAX_LEN-2:0], stream};
    assign fill_n  = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
    assign match   = accept && len != '0 && len <= LW'(MAX_LEN) && fill_n >= len
                     && ((hist_n ^ pattern) & mask) == '0;
    assign cnt_inc = (match && !(&match_count)) ? match_count + 1'b1 : match_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern     <= DEF_PATTERN;
            len         <= LW'(DEF_LEN);
            overlap     <= DEF_OVERLAP;
            history     <= '0;
            fill        <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (cfg_load) begin
            pattern     <= cfg_pattern;
            len         <= cfg_len;
            overlap     <= cfg_overlap;
            fill        <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            if (accept) begin
                history <= hist_n;
                fill    <= (match && !overlap) ? '0 : fill_n;
            end
            detected    <= match;
            match_count <= cnt_clear ? CNT_WIDTH'(match) : cnt_inc;
            count_sat   <= !cnt_clear && (count_sat || &cnt_inc);
        end
    end
endmodule
